lzss_shift_ctrl: RTL and testbench
==================================

Name: lzss_shift_ctrl

Overview:
Sequencer for the LZSS look-ahead shift buffer (pWidth x pDepth, pDepth-1 registered stages plus a combinational tail).
- Accepts the raw byte stream with a valid/ready handshake and drives the buffer's shift, clear and data inputs.
- Tracks how many registered stages hold valid bytes and tells the match engine when the window is usable.
- Executes "advance N" commands from the encoder, one shift per cycle, and flushes zeros after end-of-stream until the buffer drains.

Parameters:
pWidth, 8, symbol width in bits
pDepth, 64, buffer depth; window = pDepth-1 registered entries
pLenWidth, 7, width of advance length and count fields; must hold pDepth-1

Ports:
clk  in  1  clock
rst_x  in  1  asynchronous active-low reset
i_abort  in  1  synchronous abort: clear buffer, return to IDLE
i_s_valid  in  1  input byte valid
i_s_data  in  pWidth  input byte
i_s_last  in  1  final byte of stream
o_s_ready  out  1  input byte accepted when valid&ready
o_buf_shift  out  1  to buffer i_shift
o_buf_clear  out  1  to buffer i_clear
o_buf_d  out  pWidth  to buffer i_d: accepted byte, else zero
o_win_valid  out  1  window contents stable and usable by match engine
o_win_cnt  out  pLenWidth  valid registered entries, 0..pDepth-1
i_adv_valid  in  1  advance request
i_adv_len  in  pLenWidth  shifts requested, 1..pDepth-1
o_adv_ready  out  1  advance accepted when valid&ready
o_done  out  1  one-cycle pulse when stream fully drained

Behaviour:
- Reset: state IDLE; cnt=0; rem=0; eos=0. All outputs 0, except o_s_ready=1, which is combinational from IDLE.
- Output timing: o_buf_shift, o_buf_d and o_s_ready are combinational from state, cnt and i_s_valid; all other outputs are registered or state-decoded. o_buf_shift is asserted exactly on cycles where the buffer must shift.
- IDLE: o_s_ready=1. An accepted byte shifts in, cnt becomes 1, next state FILL. If i_s_last is set on that byte, set eos and go to WIN.
- FILL: o_s_ready=1. Each accepted byte shifts, cnt++.
  - Go to WIN when cnt reaches pDepth-1.
  - Go to WIN when a byte is accepted with i_s_last (eos=1).
  - No shift when i_s_valid=0.
- WIN: o_win_valid=1, o_adv_ready=1, o_s_ready=0.
  - On adv handshake: rem = i_adv_len, clamped to cnt when eos=1; len 0 is treated as 1. Next state ADV.
  - o_win_valid drops in the cycle after the handshake.
- ADV: one shift per cycle while rem>0.
  - eos=0: shift only when i_s_valid=1 (o_s_ready=1, byte in, cnt unchanged); otherwise stall with no shift and rem held. Accepting i_s_last sets eos.
  - eos=1: o_s_ready=0, o_buf_d=0, shift every cycle, cnt--.
  - On the shift that makes rem=0: go to DRAIN if cnt becomes 0, else WIN.
- DRAIN: o_buf_clear=1 and o_done=1 for one cycle; cnt=0, eos=0, next state IDLE.
- i_abort: highest priority after reset, in any state. o_buf_clear=1 that cycle, no shift, no handshake is accepted, next state IDLE, cnt/eos/rem cleared, o_done not asserted.
- Simultaneous events:
  - An i_s_last byte accepted during ADV while rem>1 still consumes that byte; the remaining shifts are zero-fill.
  - An advance never spans beyond cnt after eos.
- Invariants: o_buf_shift and o_buf_clear are never both 1. cnt never exceeds pDepth-1 and never underflows.
- Reset mid-operation: asynchronous return to the reset values above; the buffer is reset by the same rst_x.

Optional Feature:
LZSS_SHIFT_CTRL_STAT_EN
- Defined: adds output o_stall_cnt [15:0], a saturating count of ADV cycles with eos=0 and i_s_valid=0. It is cleared on reset, i_abort and DRAIN.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared include lzss_defines.vh holds:
  - state encodings LZSS_ST_IDLE/FILL/WIN/ADV/DRAIN (3 bits);
  - default pWidth, pDepth and pLenWidth values, which the buffer uses too.
- Single module; no sub-module is needed. Top level instantiates it beside lzss_buffer.

Test Plan:
- pDepth=8: stream 7 bytes 0x01..0x07 with no gaps -> o_s_ready falls after the 7th byte, o_win_valid=1, o_win_cnt=7, 7 shift pulses.
- Window full, adv_len=3, input valid every cycle -> 3 consecutive shifts, bytes 0x08..0x0A taken, cnt stays 7, back in WIN 3 cycles after the handshake.
- adv_len=2 with i_s_valid low for 4 cycles mid-advance -> no shifts during the gap, resumes after it; o_stall_cnt=4 when STAT_EN is defined.
- Byte 0x0B with i_s_last, then advances of 4 and 10 -> zero fill with cnt decrementing; the second advance is clamped to the remaining count; o_done pulses once with o_buf_clear, then IDLE with o_s_ready=1.
- i_abort during ADV with rem=2 -> o_buf_clear for one cycle, no shift, IDLE next cycle, cnt=0, no o_done.
- rst_x low mid-FILL -> all outputs reset immediately; restarting the stream refills from cnt=0.

Source files
------------

// File: rtl/lzss_shift_ctrl_pkg.sv
// lzss_shift_ctrl_pkg: shared defaults and state encoding for the LZSS shift buffer and its sequencer
package lzss_shift_ctrl_pkg;
  localparam int LZSS_WIDTH = 8;
  localparam int LZSS_DEPTH = 64;
  localparam int LZSS_LEN_WIDTH = 7;
  typedef enum logic [2:0] {
    LZSS_ST_IDLE  = 3'd0,
    LZSS_ST_FILL  = 3'd1,
    LZSS_ST_WIN   = 3'd2,
    LZSS_ST_ADV   = 3'd3,
    LZSS_ST_DRAIN = 3'd4
  } lzss_state_t;
endpackage

// File: rtl/lzss_shift_ctrl.sv
// lzss_shift_ctrl: sequencer for the LZSS look-ahead shift buffer
// Ports: clk/rst_x (async active-low) and i_abort; byte stream i_s_valid/i_s_data/i_s_last/o_s_ready;
// buffer controls o_buf_shift/o_buf_clear/o_buf_d; window status o_win_valid/o_win_cnt;
// advance command i_adv_valid/i_adv_len/o_adv_ready; o_done drain-complete pulse.
// Build option LZSS_SHIFT_CTRL_STAT_EN adds o_stall_cnt, a saturating count of starved advance cycles.
module lzss_shift_ctrl
  import lzss_shift_ctrl_pkg::*;
#(
  parameter int pWidth = LZSS_WIDTH,
  parameter int pDepth = LZSS_DEPTH,
  parameter int pLenWidth = LZSS_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_x,
  input  logic                 i_abort,
  input  logic                 i_s_valid,
  input  logic [pWidth-1:0]    i_s_data,
  input  logic                 i_s_last,
  output logic                 o_s_ready,
  output logic                 o_buf_shift,
  output logic                 o_buf_clear,
  output logic [pWidth-1:0]    o_buf_d,
  output logic                 o_win_valid,
  output logic [pLenWidth-1:0] o_win_cnt,
  input  logic                 i_adv_valid,
  input  logic [pLenWidth-1:0] i_adv_len,
  output logic                 o_adv_ready,
  output logic                 o_done
`ifdef LZSS_SHIFT_CTRL_STAT_EN
  ,
  output logic [15:0]          o_stall_cnt
`endif
);
  localparam logic [pLenWidth-1:0] WIN_MAX = pLenWidth'(pDepth - 1);
  lzss_state_t state, state_n;
  logic [pLenWidth-1:0] cnt, cnt_n, rem, rem_n, req;
  logic eos, eos_n, fill, accept;
  always_ff @(posedge clk or negedge rst_x)
    if (!rst_x) begin
      state <= LZSS_ST_IDLE;
      cnt <= '0;
      rem <= '0;
      eos <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rem <= rem_n;
      eos <= eos_n;
    end
  always_comb begin
    fill = state == LZSS_ST_IDLE || state == LZSS_ST_FILL;
    // after end-of-stream the advance zero-fills every cycle instead of waiting for input
    o_s_ready = !i_abort && (fill || (state == LZSS_ST_ADV && !eos));
    o_buf_shift = !i_abort && (fill ? i_s_valid : state == LZSS_ST_ADV && (eos || i_s_valid));
    accept = i_s_valid && o_s_ready;
    o_buf_d = accept ? i_s_data : '0;
    o_buf_clear = i_abort || state == LZSS_ST_DRAIN;
    o_done = !i_abort && state == LZSS_ST_DRAIN;
    o_win_valid = state == LZSS_ST_WIN;
    o_adv_ready = !i_abort && o_win_valid;
    o_win_cnt = cnt;
    // zero length means one shift; never advance past the valid entries
    req = (i_adv_len == '0) ? pLenWidth'(1) : i_adv_len;
    state_n = state;
    cnt_n = cnt;
    rem_n = rem;
    eos_n = eos;
    if (i_abort) begin
      state_n = LZSS_ST_IDLE;
      cnt_n = '0;
      rem_n = '0;
      eos_n = 1'b0;
    end else
      case (state)
        LZSS_ST_IDLE, LZSS_ST_FILL:
          if (accept) begin
            cnt_n = cnt + 1'b1;
            eos_n = i_s_last;
            state_n = (i_s_last || cnt_n == WIN_MAX) ? LZSS_ST_WIN : LZSS_ST_FILL;
          end
        LZSS_ST_WIN:
          if (i_adv_valid) begin
            rem_n = (req > cnt) ? cnt : req;
            state_n = LZSS_ST_ADV;
          end
        LZSS_ST_ADV:
          if (o_buf_shift) begin
            rem_n = rem - 1'b1;
            cnt_n = eos ? cnt - 1'b1 : cnt;
            eos_n = eos || (accept && i_s_last);
            if (rem == pLenWidth'(1)) state_n = (cnt_n == '0) ? LZSS_ST_DRAIN : LZSS_ST_WIN;
          end
        LZSS_ST_DRAIN: begin
          state_n = LZSS_ST_IDLE;
          cnt_n = '0;
          rem_n = '0;
          eos_n = 1'b0;
        end
        default: state_n = LZSS_ST_IDLE;
      endcase
  end
`ifdef LZSS_SHIFT_CTRL_STAT_EN
  always_ff @(posedge clk or negedge rst_x)
    if (!rst_x) o_stall_cnt <= '0;
    else if (i_abort || state == LZSS_ST_DRAIN) o_stall_cnt <= '0;
    else if (state == LZSS_ST_ADV && !eos && !i_s_valid && o_stall_cnt != 16'hFFFF)
      o_stall_cnt <= o_stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_lzss_shift_ctrl.sv
// tb_lzss_shift_ctrl: self-checking bench for lzss_shift_ctrl with an 8-deep window
module tb_lzss_shift_ctrl;
  localparam int D = 8;
  logic clk = 0, rst_x = 0, i_abort = 0, i_s_valid = 0, i_s_last = 0, i_adv_valid = 0;
  logic [7:0] i_s_data = 0;
  logic [6:0] i_adv_len = 0;
  logic o_s_ready, o_buf_shift, o_buf_clear, o_win_valid, o_adv_ready, o_done;
  logic [7:0] o_buf_d;
  logic [6:0] o_win_cnt;
`ifdef LZSS_SHIFT_CTRL_STAT_EN
  logic [15:0] o_stall_cnt;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  lzss_shift_ctrl #(.pWidth(8), .pDepth(D), .pLenWidth(7)) dut (
    .clk(clk), .rst_x(rst_x), .i_abort(i_abort), .i_s_valid(i_s_valid), .i_s_data(i_s_data),
    .i_s_last(i_s_last), .o_s_ready(o_s_ready), .o_buf_shift(o_buf_shift), .o_buf_clear(o_buf_clear),
    .o_buf_d(o_buf_d), .o_win_valid(o_win_valid), .o_win_cnt(o_win_cnt), .i_adv_valid(i_adv_valid),
    .i_adv_len(i_adv_len), .o_adv_ready(o_adv_ready), .o_done(o_done)
`ifdef LZSS_SHIFT_CTRL_STAT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );
  task automatic clr_in;
    i_abort = 0; i_s_valid = 0; i_s_last = 0; i_s_data = 0; i_adv_valid = 0; i_adv_len = 0;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      i_s_valid = 1; i_s_data = 8'(base + i);
      cyc();
    end
    clr_in();
  endtask
  task automatic test_reset;
    rst_x = 0; clr_in();
    #12;
    total++; if ({o_s_ready, o_buf_shift, o_buf_clear, o_win_valid, o_adv_ready, o_done} !== 6'b100000) begin bad++; $display("FAIL reset_flags got=%b exp=100000", {o_s_ready, o_buf_shift, o_buf_clear, o_win_valid, o_adv_ready, o_done}); end
    total++; if (o_win_cnt !== 7'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", o_win_cnt); end
    total++; if (o_buf_d !== 8'd0) begin bad++; $display("FAIL reset_d got=%0h exp=0", o_buf_d); end
`ifdef LZSS_SHIFT_CTRL_STAT_EN
    total++; if (o_stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", o_stall_cnt); end
`endif
    cyc(); rst_x = 1; cyc();
  endtask
  task automatic test_fill;
    int sh = 0;
    for (int i = 1; i <= 7; i++) begin
      i_s_valid = 1; i_s_data = 8'(i);
      @(negedge clk);
      sh += int'(o_buf_shift);
      total++; if (o_s_ready !== 1'b1 || o_buf_d !== 8'(i)) begin bad++; $display("FAIL fill_byte%0d got ready=%b d=%0h exp ready=1 d=%0h", i, o_s_ready, o_buf_d, i); end
      cyc();
    end
    clr_in();
    @(negedge clk);
    total++; if (sh !== 7) begin bad++; $display("FAIL fill_shifts got=%0d exp=7", sh); end
    total++; if ({o_s_ready, o_win_valid, o_adv_ready} !== 3'b011) begin bad++; $display("FAIL fill_win got=%b exp=011", {o_s_ready, o_win_valid, o_adv_ready}); end
    total++; if (o_win_cnt !== 7'd7) begin bad++; $display("FAIL fill_cnt got=%0d exp=7", o_win_cnt); end
    cyc();
  endtask
  task automatic test_advance;
    i_adv_valid = 1; i_adv_len = 3; i_s_valid = 1; i_s_data = 8'h08;
    @(negedge clk);
    total++; if (o_buf_shift !== 1'b0 || o_s_ready !== 1'b0) begin bad++; $display("FAIL adv_win_noshift got shift=%b ready=%b exp 0 0", o_buf_shift, o_s_ready); end
    cyc(); i_adv_valid = 0;
    for (int k = 0; k < 3; k++) begin
      i_s_data = 8'(8 + k);
      @(negedge clk);
      total++; if ({o_buf_shift, o_win_valid, o_buf_d} !== {2'b10, 8'(8 + k)}) begin bad++; $display("FAIL adv_shift%0d got shift=%b winv=%b d=%0h exp 1 0 %0h", k, o_buf_shift, o_win_valid, o_buf_d, 8 + k); end
      cyc();
    end
    clr_in();
    @(negedge clk);
    total++; if (o_win_valid !== 1'b1 || o_win_cnt !== 7'd7) begin bad++; $display("FAIL adv_back got winv=%b cnt=%0d exp 1 7", o_win_valid, o_win_cnt); end
    cyc();
  endtask
  task automatic test_stall;
    i_adv_valid = 1; i_adv_len = 2;
    cyc(); i_adv_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (o_buf_shift !== 1'b0 || o_s_ready !== 1'b1) begin bad++; $display("FAIL stall_gap%0d got shift=%b ready=%b exp 0 1", k, o_buf_shift, o_s_ready); end
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      i_s_valid = 1; i_s_data = 8'(8'h20 + k);
      @(negedge clk);
      total++; if (o_buf_shift !== 1'b1 || o_buf_d !== 8'(8'h20 + k)) begin bad++; $display("FAIL stall_resume%0d got shift=%b d=%0h exp 1 %0h", k, o_buf_shift, o_buf_d, 8'h20 + k); end
      cyc();
    end
    clr_in();
    @(negedge clk);
    total++; if (o_win_valid !== 1'b1 || o_win_cnt !== 7'd7) begin bad++; $display("FAIL stall_back got winv=%b cnt=%0d exp 1 7", o_win_valid, o_win_cnt); end
`ifdef LZSS_SHIFT_CTRL_STAT_EN
    total++; if (o_stall_cnt !== 16'd4) begin bad++; $display("FAIL stall_count got=%0d exp=4", o_stall_cnt); end
`endif
    cyc();
  endtask
  task automatic test_eos_drain;
    int dones = 0;
    i_adv_valid = 1; i_adv_len = 1;
    cyc(); i_adv_valid = 0;
    i_s_valid = 1; i_s_data = 8'h0B; i_s_last = 1;
    @(negedge clk);
    total++; if (o_buf_shift !== 1'b1 || o_buf_d !== 8'h0B) begin bad++; $display("FAIL eos_last got shift=%b d=%0h exp 1 0b", o_buf_shift, o_buf_d); end
    cyc(); clr_in();
    i_adv_valid = 1; i_adv_len = 4;
    cyc(); i_adv_valid = 0;
    i_s_valid = 1; i_s_data = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if ({o_s_ready, o_buf_shift, o_buf_d, o_win_cnt} !== {2'b01, 8'h00, 7'(7 - k)}) begin bad++; $display("FAIL eos_zero%0d got ready=%b shift=%b d=%0h cnt=%0d exp 0 1 0 %0d", k, o_s_ready, o_buf_shift, o_buf_d, o_win_cnt, 7 - k); end
      cyc();
    end
    @(negedge clk);
    total++; if (o_win_valid !== 1'b1 || o_win_cnt !== 7'd3) begin bad++; $display("FAIL eos_win got winv=%b cnt=%0d exp 1 3", o_win_valid, o_win_cnt); end
    i_adv_valid = 1; i_adv_len = 10;
    cyc(); i_adv_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dones += int'(o_done);
      if (k < 3) begin
        total++; if (o_buf_shift !== 1'b1 || o_win_cnt !== 7'(3 - k)) begin bad++; $display("FAIL clamp_shift%0d got shift=%b cnt=%0d exp 1 %0d", k, o_buf_shift, o_win_cnt, 3 - k); end
      end else begin
        total++; if ({o_done, o_buf_clear, o_buf_shift} !== 3'b110) begin bad++; $display("FAIL drain got done=%b clear=%b shift=%b exp 1 1 0", o_done, o_buf_clear, o_buf_shift); end
      end
      cyc();
    end
    clr_in();
    @(negedge clk);
    dones += int'(o_done);
    total++; if (dones !== 1) begin bad++; $display("FAIL done_count got=%0d exp=1", dones); end
    total++; if (o_s_ready !== 1'b1 || o_win_cnt !== 7'd0 || o_win_valid !== 1'b0) begin bad++; $display("FAIL drain_idle got ready=%b cnt=%0d winv=%b exp 1 0 0", o_s_ready, o_win_cnt, o_win_valid); end
`ifdef LZSS_SHIFT_CTRL_STAT_EN
    total++; if (o_stall_cnt !== 16'd0) begin bad++; $display("FAIL drain_stall got=%0d exp=0", o_stall_cnt); end
`endif
    cyc();
  endtask
  task automatic test_abort;
    feed(7, 8'h30);
    i_adv_valid = 1; i_adv_len = 3;
    cyc(); i_adv_valid = 0;
    i_s_valid = 1; i_s_data = 8'h40;
    cyc();
    i_abort = 1; i_s_data = 8'h41;
    @(negedge clk);
    total++; if ({o_buf_clear, o_buf_shift, o_done, o_s_ready} !== 4'b1000) begin bad++; $display("FAIL abort_cycle got clear=%b shift=%b done=%b ready=%b exp 1 0 0 0", o_buf_clear, o_buf_shift, o_done, o_s_ready); end
    cyc(); clr_in();
    @(negedge clk);
    total++; if ({o_s_ready, o_win_valid, o_done, o_buf_clear, o_win_cnt} !== {4'b1000, 7'd0}) begin bad++; $display("FAIL abort_idle got ready=%b winv=%b done=%b clear=%b cnt=%0d exp 1 0 0 0 0", o_s_ready, o_win_valid, o_done, o_buf_clear, o_win_cnt); end
    cyc();
  endtask
  task automatic test_async_reset;
    int sh = 0;
    feed(3, 8'h50);
    i_s_valid = 1; i_s_data = 8'h53;
    #2 rst_x = 0; i_s_valid = 0;
    #1;
    total++; if ({o_s_ready, o_buf_shift, o_buf_clear, o_win_valid, o_adv_ready, o_done, o_win_cnt} !== {6'b100000, 7'd0}) begin bad++; $display("FAIL async_reset got flags=%b cnt=%0d exp 100000 0", {o_s_ready, o_buf_shift, o_buf_clear, o_win_valid, o_adv_ready, o_done}, o_win_cnt); end
    cyc(); rst_x = 1; cyc();
    for (int i = 0; i < 7; i++) begin
      i_s_valid = 1; i_s_data = 8'(8'h60 + i);
      @(negedge clk);
      sh += int'(o_buf_shift);
      total++; if (o_win_cnt !== 7'(i)) begin bad++; $display("FAIL refill_cnt%0d got=%0d exp=%0d", i, o_win_cnt, i); end
      cyc();
    end
    clr_in();
    @(negedge clk);
    total++; if (sh !== 7 || o_win_cnt !== 7'd7 || o_win_valid !== 1'b1) begin bad++; $display("FAIL refill_win got shifts=%0d cnt=%0d winv=%b exp 7 7 1", sh, o_win_cnt, o_win_valid); end
    rst_x = 0; cyc(); rst_x = 1; cyc();
  endtask
  task automatic test_random;
    for (int s = 0; s < 8; s++) begin
      logic [7:0] src[$];
      int mode = 0, cnt = 0, rem = 0, stall = 0, budget = 0;
      bit eos = 0, fin = 0;
      int n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) src.push_back(8'($urandom));
      while (!fin && budget < 500) begin
        bit sv, last, av, er, esh, acc;
        logic [7:0] ed;
        logic [6:0] len;
        budget++;
        sv = src.size() > 0 && ($urandom % 4) != 0;
        last = src.size() == 1;
        av = $urandom % 2;
        len = 7'($urandom_range(0, 7));
        i_s_valid = sv; i_s_data = sv ? src[0] : 8'($urandom); i_s_last = sv && last;
        i_adv_valid = av; i_adv_len = len;
        er = mode == 0 || (mode == 2 && !eos);
        esh = (mode == 0 && sv) || (mode == 2 && (eos || sv));
        acc = er && sv;
        ed = acc ? src[0] : 8'h00;
        @(negedge clk);
        total++; if ({o_s_ready, o_buf_shift, o_buf_clear, o_win_valid, o_adv_ready, o_done, o_win_cnt, o_buf_d} !== {er, esh, mode == 3, mode == 1, mode == 1, mode == 3, 7'(cnt), ed}) begin
          bad++; $display("FAIL rand_s%0d_c%0d got rdy=%b sh=%b clr=%b wv=%b ar=%b dn=%b cnt=%0d d=%0h exp %b %b %b %b %b %b %0d %0h", s, budget, o_s_ready, o_buf_shift, o_buf_clear, o_win_valid, o_adv_ready, o_done, o_win_cnt, o_buf_d, er, esh, mode == 3, mode == 1, mode == 1, mode == 3, cnt, ed);
        end
`ifdef LZSS_SHIFT_CTRL_STAT_EN
        total++; if (o_stall_cnt !== 16'(stall)) begin bad++; $display("FAIL rand_stall got=%0d exp=%0d", o_stall_cnt, stall); end
        if (mode == 2 && !eos && !sv && stall < 65535) stall++;
        if (mode == 3) stall = 0;
`endif
        if (acc) void'(src.pop_front());
        case (mode)
          0: if (acc) begin
               cnt++;
               if (last) eos = 1;
               if (last || cnt == D - 1) mode = 1;
             end
          1: if (av) begin
               rem = (len == 0) ? 1 : int'(len);
               if (rem > cnt) rem = cnt;
               mode = 2;
             end
          2: if (esh) begin
               rem--;
               if (eos) cnt--;
               else if (acc && last) eos = 1;
               if (rem == 0) mode = (cnt == 0) ? 3 : 1;
             end
          default: begin
            cnt = 0; eos = 0; mode = 0; fin = 1;
          end
        endcase
        cyc();
      end
      clr_in();
      total++; if (!fin) begin bad++; $display("FAIL rand_timeout stream %0d got no drain within %0d cycles", s, budget); end
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_advance();
    test_stall();
    test_eos_drain();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
